// File: rtl/sc_game_status_responder_if.sv
// rtl/sc_game_status_responder_if.sv - command/flag bundle between game FSM and status responder
interface sc_game_status_responder_if #(
  parameter int LIVES_WIDTH = 3,
  parameter int LEVEL_WIDTH = 3
);
  // Active-low command strobes from the FSM
  logic                   SC_GAMESTATUS_Clear_InLow;
  logic                   SC_GAMESTATUS_ClearLost_InLow;
  logic [1:0]             SC_GAMESTATUS_LifesSignal_InBUS;
  logic                   SC_GAMESTATUS_TransitionCounter1_InLow;
  logic                   SC_GAMESTATUS_TransitionTime_InLow;
  logic                   SC_GAMESTATUS_SpeedClear_InLow;
  // Status values and comparator flags back to the FSM / display
  logic [LIVES_WIDTH-1:0] SC_GAMESTATUS_Lives_OutBUS;
  logic [LEVEL_WIDTH-1:0] SC_GAMESTATUS_Level_OutBUS;
  logic                   SC_GAMESTATUS_LifesComparator_OutLow;
  logic                   SC_GAMESTATUS_WINComparator_OutLow;
  logic                   SC_GAMESTATUS_TransitionTimeComparator_OutLow;
  logic                   SC_GAMESTATUS_Lost_OutHigh;
  logic                   SC_GAMESTATUS_SpeedTick_OutHigh;
  logic                   SC_GAMESTATUS_Error_OutHigh;

  // FSM side: issues commands, reads flags
  modport master (
    output SC_GAMESTATUS_Clear_InLow,
    output SC_GAMESTATUS_ClearLost_InLow,
    output SC_GAMESTATUS_LifesSignal_InBUS,
    output SC_GAMESTATUS_TransitionCounter1_InLow,
    output SC_GAMESTATUS_TransitionTime_InLow,
    output SC_GAMESTATUS_SpeedClear_InLow,
    input  SC_GAMESTATUS_Lives_OutBUS,
    input  SC_GAMESTATUS_Level_OutBUS,
    input  SC_GAMESTATUS_LifesComparator_OutLow,
    input  SC_GAMESTATUS_WINComparator_OutLow,
    input  SC_GAMESTATUS_TransitionTimeComparator_OutLow,
    input  SC_GAMESTATUS_Lost_OutHigh,
    input  SC_GAMESTATUS_SpeedTick_OutHigh,
    input  SC_GAMESTATUS_Error_OutHigh
  );

  // Responder side: consumes commands, produces flags
  modport slave (
    input  SC_GAMESTATUS_Clear_InLow,
    input  SC_GAMESTATUS_ClearLost_InLow,
    input  SC_GAMESTATUS_LifesSignal_InBUS,
    input  SC_GAMESTATUS_TransitionCounter1_InLow,
    input  SC_GAMESTATUS_TransitionTime_InLow,
    input  SC_GAMESTATUS_SpeedClear_InLow,
    output SC_GAMESTATUS_Lives_OutBUS,
    output SC_GAMESTATUS_Level_OutBUS,
    output SC_GAMESTATUS_LifesComparator_OutLow,
    output SC_GAMESTATUS_WINComparator_OutLow,
    output SC_GAMESTATUS_TransitionTimeComparator_OutLow,
    output SC_GAMESTATUS_Lost_OutHigh,
    output SC_GAMESTATUS_SpeedTick_OutHigh,
    output SC_GAMESTATUS_Error_OutHigh
  );
endinterface

// File: rtl/sc_game_status_responder.sv
// rtl/sc_game_status_responder.sv - lives/level/timer/speed datapath answering the game FSM
module sc_game_status_responder #(
  parameter int LIVES_INIT   = 3,
  parameter int LIVES_MAX    = 7,
  parameter int LIVES_WIDTH  = 3,
  parameter int LEVEL_MAX    = 4,
  parameter int LEVEL_WIDTH  = 3,
  parameter int TRANS_CYCLES = 50000000,
  parameter int TRANS_WIDTH  = 26,
  parameter int TICK_BASE    = 25000000,
  parameter int TICK_STEP    = 5000000,
  parameter int TICK_WIDTH   = 25
) (
  input  logic SC_STATEMACHINEGAME_CLOCK_50,
  input  logic SC_STATEMACHINEGAME_RESET_InHigh,
  sc_game_status_responder_if.slave bus
);

  localparam logic [LIVES_WIDTH-1:0] LIVES_INIT_V = LIVES_WIDTH'(LIVES_INIT);
  localparam logic [LIVES_WIDTH-1:0] LIVES_MAX_V  = LIVES_WIDTH'(LIVES_MAX);
  localparam logic [LIVES_WIDTH-1:0] LIVES_ONE    = LIVES_WIDTH'(1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX_V  = LEVEL_WIDTH'(LEVEL_MAX);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_ONE    = LEVEL_WIDTH'(1);
  localparam logic [TRANS_WIDTH-1:0] TRANS_LAST   = TRANS_WIDTH'(TRANS_CYCLES - 1);
  localparam logic [TRANS_WIDTH-1:0] TRANS_ONE    = TRANS_WIDTH'(1);
  localparam logic [TICK_WIDTH-1:0]  TICK_ONE     = TICK_WIDTH'(1);

  logic [LIVES_WIDTH-1:0] lives_q, lives_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [TRANS_WIDTH-1:0] timer_q, timer_d;
  logic [TICK_WIDTH-1:0]  speed_q, speed_d;
  logic                   lost_q, lost_d;
  logic                   error_q, error_d;
  logic [TICK_WIDTH-1:0]  period;
  logic [TICK_WIDTH-1:0]  period_last;

  // Tick period shrinks with the registered level; parameters guarantee it stays positive
  assign period      = TICK_WIDTH'(TICK_BASE) - TICK_WIDTH'(level_q) * TICK_WIDTH'(TICK_STEP);
  assign period_last = period - TICK_ONE;

  // Next-state for every counter; clear overrides all other commands in the same cycle
  always_comb begin
    lives_d = lives_q;
    level_d = level_q;
    timer_d = timer_q;
    speed_d = speed_q;
    lost_d  = lost_q;
    error_d = error_q;
    if (!bus.SC_GAMESTATUS_Clear_InLow) begin
      lives_d = LIVES_INIT_V;
      level_d = '0;
      timer_d = '0;
      speed_d = '0;
      lost_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      // Lives command is level-sensitive: one step per cycle the code is held
      case (bus.SC_GAMESTATUS_LifesSignal_InBUS)
        2'b10:   if (lives_q != '0) lives_d = lives_q - LIVES_ONE;
        2'b01:   if (lives_q != LIVES_MAX_V) lives_d = lives_q + LIVES_ONE;
        2'b00:   error_d = 1'b1;
        default: lives_d = lives_q;
      endcase

      if (!bus.SC_GAMESTATUS_TransitionCounter1_InLow && level_q != LEVEL_MAX_V)
        level_d = level_q + LEVEL_ONE;

      if (!bus.SC_GAMESTATUS_ClearLost_InLow)
        lost_d = 1'b1;

      // Run input high restarts the WAIT timer; low counts up and parks on the last value
      if (bus.SC_GAMESTATUS_TransitionTime_InLow)
        timer_d = '0;
      else if (timer_q != TRANS_LAST)
        timer_d = timer_q + TRANS_ONE;

      // ">=" also catches a count stranded above a freshly shortened period
      if (!bus.SC_GAMESTATUS_SpeedClear_InLow)
        speed_d = '0;
      else if (speed_q >= period_last)
        speed_d = '0;
      else
        speed_d = speed_q + TICK_ONE;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge SC_STATEMACHINEGAME_CLOCK_50 or posedge SC_STATEMACHINEGAME_RESET_InHigh) begin
    if (SC_STATEMACHINEGAME_RESET_InHigh) begin
      lives_q <= LIVES_INIT_V;
      level_q <= '0;
      timer_q <= '0;
      speed_q <= '0;
      lost_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      lives_q <= lives_d;
      level_q <= level_d;
      timer_q <= timer_d;
      speed_q <= speed_d;
      lost_q  <= lost_d;
      error_q <= error_d;
    end
  end

  assign bus.SC_GAMESTATUS_Lives_OutBUS                    = lives_q;
  assign bus.SC_GAMESTATUS_Level_OutBUS                    = level_q;
  assign bus.SC_GAMESTATUS_LifesComparator_OutLow          = (lives_q != '0);
  assign bus.SC_GAMESTATUS_WINComparator_OutLow            = (level_q != LEVEL_MAX_V);
  assign bus.SC_GAMESTATUS_TransitionTimeComparator_OutLow = (timer_q != TRANS_LAST);
  assign bus.SC_GAMESTATUS_Lost_OutHigh                    = lost_q;
  assign bus.SC_GAMESTATUS_Error_OutHigh                   = error_q;
  // Tick only on an exact hit, and never while the counter is being held or cleared
  assign bus.SC_GAMESTATUS_SpeedTick_OutHigh = bus.SC_GAMESTATUS_Clear_InLow &&
                                               bus.SC_GAMESTATUS_SpeedClear_InLow &&
                                               (speed_q == period_last);

endmodule

// File: tb/tb_sc_game_status_responder.sv
// tb/tb_sc_game_status_responder.sv - vector and sequence bench for sc_game_status_responder
module tb_sc_game_status_responder;

  logic clk;
  logic rst;

  sc_game_status_responder_if #(.LIVES_WIDTH(3), .LEVEL_WIDTH(3)) bus ();

  sc_game_status_responder #(
    .LIVES_INIT(3), .LIVES_MAX(7), .LIVES_WIDTH(3),
    .LEVEL_MAX(4), .LEVEL_WIDTH(3),
    .TRANS_CYCLES(8), .TRANS_WIDTH(4),
    .TICK_BASE(10), .TICK_STEP(2), .TICK_WIDTH(5)
  ) dut (
    .SC_STATEMACHINEGAME_CLOCK_50     (clk),
    .SC_STATEMACHINEGAME_RESET_InHigh (rst),
    .bus                              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr_n;
    logic       lost_n;
    logic [1:0] lifes;
    logic       lvl_n;
    logic [2:0] e_lives;
    logic [2:0] e_level;
    logic       e_lcomp;
    logic       e_wcomp;
    logic       e_lost;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic clr_n, input logic lost_n, input logic [1:0] lifes, input logic lvl_n,
                     input logic [2:0] lv, input logic [2:0] lev, input logic lc, input logic wc,
                     input logic lo, input logic er);
    vec_t v;
    v = '{clr_n, lost_n, lifes, lvl_n, lv, lev, lc, wc, lo, er};
    vecs.push_back(v);
  endtask

  function automatic logic [9:0] status();
    return {bus.SC_GAMESTATUS_Lives_OutBUS, bus.SC_GAMESTATUS_Level_OutBUS,
            bus.SC_GAMESTATUS_LifesComparator_OutLow, bus.SC_GAMESTATUS_WINComparator_OutLow,
            bus.SC_GAMESTATUS_Lost_OutHigh, bus.SC_GAMESTATUS_Error_OutHigh};
  endfunction

  task automatic idle();
    bus.SC_GAMESTATUS_Clear_InLow              = 1'b1;
    bus.SC_GAMESTATUS_ClearLost_InLow          = 1'b1;
    bus.SC_GAMESTATUS_LifesSignal_InBUS        = 2'b11;
    bus.SC_GAMESTATUS_TransitionCounter1_InLow = 1'b1;
  endtask

  initial begin
    int ticks;
    n_pass  = 0;
    n_total = 0;

    // clr_n lost_n lifes lvl_n | lives level lcomp wcomp lost err
    add(1, 1, 2'b10, 1, 3'd2, 3'd0, 1, 1, 0, 0);
    add(1, 1, 2'b10, 1, 3'd1, 3'd0, 1, 1, 0, 0);
    add(1, 1, 2'b10, 1, 3'd0, 3'd0, 0, 1, 0, 0);
    add(1, 1, 2'b10, 1, 3'd0, 3'd0, 0, 1, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(1, 1, 2'b01, 1, (i > 7) ? 3'd7 : 3'(i), 3'd0, 1, 1, 0, 0);
    add(1, 1, 2'b00, 1, 3'd7, 3'd0, 1, 1, 0, 1);
    add(1, 1, 2'b11, 0, 3'd7, 3'd1, 1, 1, 0, 1);
    add(1, 1, 2'b11, 0, 3'd7, 3'd2, 1, 1, 0, 1);
    add(1, 1, 2'b11, 0, 3'd7, 3'd3, 1, 1, 0, 1);
    add(1, 1, 2'b11, 0, 3'd7, 3'd4, 1, 0, 0, 1);
    add(1, 1, 2'b11, 0, 3'd7, 3'd4, 1, 0, 0, 1);
    add(1, 1, 2'b10, 0, 3'd6, 3'd4, 1, 0, 0, 1);
    add(1, 0, 2'b11, 1, 3'd6, 3'd4, 1, 0, 1, 1);
    add(0, 0, 2'b10, 0, 3'd3, 3'd0, 1, 1, 0, 0);
    add(1, 1, 2'b11, 1, 3'd3, 3'd0, 1, 1, 0, 0);

    idle();
    bus.SC_GAMESTATUS_TransitionTime_InLow = 1'b1;
    bus.SC_GAMESTATUS_SpeedClear_InLow     = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_status", 32'(status()), 32'({3'd3, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
    check("reset_trans_comp", 32'(bus.SC_GAMESTATUS_TransitionTimeComparator_OutLow), 32'd1);
    check("reset_tick", 32'(bus.SC_GAMESTATUS_SpeedTick_OutHigh), 32'd0);

    foreach (vecs[i]) begin
      bus.SC_GAMESTATUS_Clear_InLow              = vecs[i].clr_n;
      bus.SC_GAMESTATUS_ClearLost_InLow          = vecs[i].lost_n;
      bus.SC_GAMESTATUS_LifesSignal_InBUS        = vecs[i].lifes;
      bus.SC_GAMESTATUS_TransitionCounter1_InLow = vecs[i].lvl_n;
      step();
      check($sformatf("vec%0d", i), 32'(status()),
            32'({vecs[i].e_lives, vecs[i].e_level, vecs[i].e_lcomp, vecs[i].e_wcomp,
                 vecs[i].e_lost, vecs[i].e_err}));
    end
    idle();

    // Transition timer: comparator low from the 8th run cycle onward
    bus.SC_GAMESTATUS_TransitionTime_InLow = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("trans_cyc%0d", k), 32'(bus.SC_GAMESTATUS_TransitionTimeComparator_OutLow),
            (k >= 8) ? 32'd0 : 32'd1);
      step();
    end
    bus.SC_GAMESTATUS_TransitionTime_InLow = 1'b1;
    step();
    check("trans_release", 32'(bus.SC_GAMESTATUS_TransitionTimeComparator_OutLow), 32'd1);

    // Speed tick at level 0: period 10
    bus.SC_GAMESTATUS_SpeedClear_InLow = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      check($sformatf("tick_l0_cyc%0d", k), 32'(bus.SC_GAMESTATUS_SpeedTick_OutHigh),
            (k % 10 == 0) ? 32'd1 : 32'd0);
      step();
    end

    // Raise to level 2 while held clear, then period 6
    bus.SC_GAMESTATUS_SpeedClear_InLow         = 1'b0;
    bus.SC_GAMESTATUS_TransitionCounter1_InLow = 1'b0;
    step();
    step();
    bus.SC_GAMESTATUS_TransitionCounter1_InLow = 1'b1;
    step();
    check("level_two", 32'(bus.SC_GAMESTATUS_Level_OutBUS), 32'd2);
    bus.SC_GAMESTATUS_SpeedClear_InLow = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("tick_l2_cyc%0d", k), 32'(bus.SC_GAMESTATUS_SpeedTick_OutHigh),
            (k % 6 == 0) ? 32'd1 : 32'd0);
      step();
    end

    // Speed clear held low suppresses every tick
    bus.SC_GAMESTATUS_SpeedClear_InLow = 1'b0;
    ticks = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.SC_GAMESTATUS_SpeedTick_OutHigh) ticks++;
      step();
    end
    check("tick_suppressed", 32'(ticks), 32'd0);

    // Level rises to 3 (period 4) while count is 3: count 4 wraps silently, next tick at count 3
    bus.SC_GAMESTATUS_SpeedClear_InLow = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      bus.SC_GAMESTATUS_TransitionCounter1_InLow = (k == 4) ? 1'b0 : 1'b1;
      check($sformatf("tick_wrap_cyc%0d", k), 32'(bus.SC_GAMESTATUS_SpeedTick_OutHigh),
            (k == 9) ? 32'd1 : 32'd0);
      step();
    end
    bus.SC_GAMESTATUS_TransitionCounter1_InLow = 1'b1;

    // Set lost, start the timer, then reset asynchronously mid-cycle
    bus.SC_GAMESTATUS_ClearLost_InLow      = 1'b0;
    bus.SC_GAMESTATUS_LifesSignal_InBUS    = 2'b10;
    bus.SC_GAMESTATUS_TransitionTime_InLow = 1'b0;
    step();
    bus.SC_GAMESTATUS_ClearLost_InLow   = 1'b1;
    bus.SC_GAMESTATUS_LifesSignal_InBUS = 2'b11;
    check("pre_reset_status", 32'(status()), 32'({3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0}));
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_status", 32'(status()), 32'({3'd3, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
    check("async_reset_flags", 32'({bus.SC_GAMESTATUS_TransitionTimeComparator_OutLow,
                                    bus.SC_GAMESTATUS_SpeedTick_OutHigh}), 32'b10);
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sc_game_status_responder.md
Name: sc_game_status_responder

Overview:
- Datapath responder on the far end of the game state machine's control interface.
- Consumes the FSM's active-low command strobes: lives up/down, level advance, transition timer run, speed counter clear, lost flag, global clear.
- Returns the comparator flags the FSM branches on: lives exhausted, win level reached, transition time elapsed.
- Also drives lives/level values, lost flag and level-dependent game-speed tick to display and object-movement logic.

Parameters:
LIVES_INIT, 3, lives loaded on reset/clear
LIVES_MAX, 7, lives saturation ceiling
LIVES_WIDTH, 3, lives register width
LEVEL_MAX, 4, level at which win comparator asserts
LEVEL_WIDTH, 3, level register width
TRANS_CYCLES, 50000000, WAIT-state duration in clocks (1 s at 50 MHz)
TRANS_WIDTH, 26, transition counter width
TICK_BASE, 25000000, speed tick period at level 0
TICK_STEP, 5000000, period reduction per level; TICK_BASE > LEVEL_MAX*TICK_STEP required
TICK_WIDTH, 25, speed counter width

Ports:
SC_STATEMACHINEGAME_CLOCK_50  in  1  system clock, 50 MHz
SC_STATEMACHINEGAME_RESET_InHigh  in  1  asynchronous, active-high reset
SC_GAMESTATUS_Clear_InLow  in  1  synchronous global clear
SC_GAMESTATUS_ClearLost_InLow  in  1  set lost flag
SC_GAMESTATUS_LifesSignal_InBUS  in  2  lives command: 11 hold, 10 decrement, 01 increment, 00 illegal
SC_GAMESTATUS_TransitionCounter1_InLow  in  1  level advance strobe
SC_GAMESTATUS_TransitionTime_InLow  in  1  low = run transition timer; high = clear it
SC_GAMESTATUS_SpeedClear_InLow  in  1  low = hold speed counter at 0
SC_GAMESTATUS_Lives_OutBUS  out  LIVES_WIDTH  current lives
SC_GAMESTATUS_Level_OutBUS  out  LEVEL_WIDTH  current level
SC_GAMESTATUS_LifesComparator_OutLow  out  1  low iff lives == 0
SC_GAMESTATUS_WINComparator_OutLow  out  1  low iff level == LEVEL_MAX
SC_GAMESTATUS_TransitionTimeComparator_OutLow  out  1  low iff timer == TRANS_CYCLES-1
SC_GAMESTATUS_Lost_OutHigh  out  1  sticky lost flag
SC_GAMESTATUS_SpeedTick_OutHigh  out  1  one-cycle game-speed pulse
SC_GAMESTATUS_Error_OutHigh  out  1  sticky illegal-command flag

Behaviour:
- Reset (async) and Clear_InLow=0 (sync) give identical state:
  - lives=LIVES_INIT, level=0, timer=0, speed count=0.
  - Lost=0, Error=0, SpeedTick=0.
  - LifesComp=1, WINComp=1, TransComp=1.
- Clear has priority over every other input in the same cycle.
- All counters are registered. Comparators are combinational from registers.
  - A strobe asserted in cycle N is visible on the outputs in cycle N+1, which is the FSM's next-state cycle.
- Lives (one update per cycle the code is present; strobes are level-sensitive, no edge detect):
  - 10: decrement, saturating at 0.
  - 01: increment, saturating at LIVES_MAX.
  - 11: hold.
  - 00: hold and set Error (sticky until reset/clear).
- Level:
  - +1 each cycle TransitionCounter1_InLow=0, saturating at LEVEL_MAX.
  - Independent of lives updates; simultaneous lives and level commands both apply.
- Lost: set when ClearLost_InLow=0; cleared only by reset/clear.
- Transition timer:
  - TransitionTime_InLow=1: timer=0.
  - TransitionTime_InLow=0: increments, saturating at TRANS_CYCLES-1.
  - TransComp low while timer == TRANS_CYCLES-1.
  - A WAIT phase entered with timer=0 therefore lasts exactly TRANS_CYCLES cycles.
  - Deasserting the run input mid-count restarts from 0.
- Speed counter:
  - Period P = TICK_BASE - level*TICK_STEP, computed from the registered level.
  - SpeedClear_InLow=0: count=0, no tick.
  - Otherwise count increments; on count == P-1, SpeedTick=1 for that cycle only, and count wraps to 0 next cycle.
  - If level changes so that count > P-1, count wraps to 0 on the next cycle without a tick.
- Unused width bits are zero; no arithmetic overflow is possible given the saturation rules.
- Reset mid-operation aborts all counting immediately; outputs return to reset values asynchronously.

Test Plan:
- Reset, then 3 cycles of LifesSignal=10 -> Lives 3,2,1,0; LifesComp=0 from cycle after third strobe; a 4th decrement keeps Lives=0.
- LifesSignal=01 for 6 cycles from Lives=3 -> Lives saturates at 7; LifesSignal=00 one cycle -> Error=1, Lives unchanged at 7.
- TransitionCounter1 pulsed 5 times -> Level 1..4, WINComp=0 at Level=4, 5th pulse leaves Level=4.
- TRANS_CYCLES=8, TransitionTime_InLow=0 held -> TransComp low first in the 8th cycle of run and stays low; raise input -> TransComp=1, timer=0 next cycle.
- TICK_BASE=10, TICK_STEP=2: at level 0, ticks every 10 cycles; at level 2, every 6 cycles; SpeedClear low suppresses ticks.
- Clear_InLow=0 concurrently with LifesSignal=10, ClearLost=0 and TransitionCounter1=0 -> Lives=3, Level=0, Lost=0; a mid-count reset yields all reset values immediately.
